// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced over WIDTH cycles.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] rb_load;
  logic             cin_load;
  logic             ha1_s, ha1_c, ha2_s, ha2_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject the +1 through the carry.
  assign rb_load  = sub ? ~b : b;
  assign cin_load = sub;
`else
  assign rb_load  = b;
  assign cin_load = 1'b0;
`endif

  assign ha1_s = ra_q[0] ^ rb_q[0];
  assign ha1_c = ra_q[0] & rb_q[0];
  assign ha2_s = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = rb_load;
          carry_d = cin_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        carry_d = ha1_c | ha2_c;
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // The carry flop doubles as cout: it is only reloaded on an accepted start.
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned add, or a + (2^W - b) for subtract, modulo 2^(W+1).
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int unsigned r;
    if (s) r = int'(x) + (32'd1 << W) - int'(y);
    else   r = int'(x) + int'(y);
    return r[W:0];
  endfunction

  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    start = 1'b1;
    a     = ta;
    b     = tb_;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = ts;
`else
    if (ts) $display("note: subtract requested without subtract build");
`endif
  endtask

  // Launch one operation, check busy length, latency, result and hold.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic [W-1:0] es, input logic ec);
    int n, busy_cnt;
    bit both;
    logic [W:0] held;
    drive_op(ta, tb_, ts);
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    n = 0; busy_cnt = 0; both = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && done === 1'b1) both = 1;
      tick();
      n++;
    end
    if (busy === 1'b1 && done === 1'b1) both = 1;
    check({name, " latency"}, n, W);
    check({name, " busy_cycles"}, busy_cnt, W);
    check({name, " busy_and_done"}, {31'd0, both}, 0);
    check({name, " result"}, {cout, sum}, {ec, es});
    held = {ec, es};
    tick();
    tick();
    check({name, " held"}, {done, cout, sum}, {1'b0, held});
  endtask

  initial begin
    int t1, t2, dcnt, k;
    logic [W-1:0] ra, rb, dsum;
    logic rs;
    logic [W:0] m;

    vecs.push_back('{"add05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0});
    vecs.push_back('{"addFF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"addAA_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{"addFF_FF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{"add80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"add00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{"sub05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{"sub03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{"sub07_00", 8'h07, 8'h00, 1'b1, 8'h07, 1'b1});
    vecs.push_back('{"sub42_42", 8'h42, 8'h42, 1'b1, 8'h00, 1'b1});
    sub = 1'b0;
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    tick();
    tick();
    check("reset_outputs", {busy, done, cout, sum}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c);

    // start pulsed in the 3rd busy cycle must be ignored
    drive_op(8'h05, 8'h03, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    drive_op(8'h10, 8'h10, 1'b0);
    tick();
    start = 1'b0;
    dcnt = 0; dsum = '0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        dcnt++;
        dsum = sum;
      end
      tick();
    end
    check("ignore_busy done_count", dcnt, 1);
    check("ignore_busy sum", dsum, 8'h08);

    // asynchronous reset in the 4th busy cycle
    drive_op(8'h05, 8'h03, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset outputs", {busy, done, cout, sum}, 0);
    tick();
    check("mid_reset no_done", {busy, done}, 0);
    rst_n = 1'b1;
    run_op("after_reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // back-to-back with start held high
    drive_op(8'h0F, 8'h01, 1'b0);
    tick();
    a = 8'h20;
    b = 8'h22;
    k = 0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    t1 = cyc;
    check("b2b first_sum", {cout, sum}, {1'b0, 8'h10});
    tick();
    start = 1'b0;
    check("b2b rebusy", {busy, done}, 2'b10);
    k = 0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    t2 = cyc;
    check("b2b spacing", t2 - t1, W + 1);
    check("b2b second_sum", {cout, sum}, {1'b0, 8'h42});
    tick();

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i < 4) rb = ~ra;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rs);
      run_op("random", ra, rb, rs, m[W-1:0], m[W]);
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
